// File: rtl/example_text_loader_pkg.sv
// rtl/example_text_loader_pkg.sv - shared types and constants for the text memory loader
package example_text_loader_pkg;

  localparam int TEXT_BITS             = 12;
  localparam int TEXT_LOADER_HDR_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CHECK,
    DONE,
    ERROR
  } text_loader_state_e;

endpackage

// File: rtl/text_word_assembler.sv
// rtl/text_word_assembler.sv - packs little-endian bytes into a 32-bit word
import example_text_loader_pkg::*;

module text_word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_complete
);

  localparam int              IDX_BITS = $clog2(TEXT_LOADER_HDR_BYTES);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(TEXT_LOADER_HDR_BYTES - 1);

  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [31:0]         word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d = '0;
    end else if (byte_valid) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_data;
      idx_d = idx_q + 1'b1;
    end
  end

  // word carries the byte being accepted, so the full word is visible on its last byte
  assign word          = word_d;
  assign word_complete = byte_valid && !clear && (idx_q == LAST_IDX);

  always_ff @(posedge clock) begin
    if (!reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/example_text_loader.sv
// rtl/example_text_loader.sv - streams a checksummed program image into text memory
import example_text_loader_pkg::*;

module example_text_loader #(
  parameter int WORD_ADDR_BITS = TEXT_BITS - 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      mem_we,
  output logic [WORD_ADDR_BITS-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [WORD_ADDR_BITS:0]   words_loaded,
  output logic                      cpu_reset,
  output logic                      done,
  output logic                      error
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << WORD_ADDR_BITS;

  text_loader_state_e          state_q, state_d;
  logic [WORD_ADDR_BITS:0]     count_q, count_d;
  logic [WORD_ADDR_BITS:0]     words_loaded_q, words_loaded_d;
  logic [WORD_ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]                 mem_wdata_q, mem_wdata_d;
  logic [7:0]                  checksum_q, checksum_d;
  logic                        mem_we_q, mem_we_d;

  logic        accept;
  logic        asm_valid;
  logic [31:0] asm_word;
  logic        asm_complete;

  assign in_ready  = (state_q == HDR) || (state_q == DATA) || (state_q == CHECK);
  assign accept    = in_valid && in_ready;
  assign asm_valid = accept && ((state_q == HDR) || (state_q == DATA));

  text_word_assembler u_asm (
    .clock         (clock),
    .reset         (reset),
    .clear         (state_q == IDLE),
    .byte_valid    (asm_valid),
    .byte_data     (in_data),
    .word          (asm_word),
    .word_complete (asm_complete)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    words_loaded_d = words_loaded_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    checksum_d     = checksum_q;
    mem_we_d       = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = HDR;
      HDR: begin
        if (asm_complete) begin
          if (asm_word > MAX_WORDS) begin
            state_d = ERROR;
          end else if (asm_word == '0) begin
            state_d = CHECK;
          end else begin
            count_d = asm_word[WORD_ADDR_BITS:0];
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          checksum_d = checksum_q ^ in_data;
          if (asm_complete) begin
            mem_we_d       = 1'b1;
            mem_addr_d     = words_loaded_q[WORD_ADDR_BITS-1:0];
            mem_wdata_d    = asm_word;
            words_loaded_d = words_loaded_q + 1'b1;
            if (words_loaded_d == count_q) state_d = CHECK;
          end
        end
      end
      CHECK: if (accept) state_d = (in_data == checksum_q) ? DONE : ERROR;
      DONE:  state_d = DONE;
      ERROR: state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      words_loaded_q <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      checksum_q     <= '0;
      mem_we_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      words_loaded_q <= words_loaded_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      checksum_q     <= checksum_d;
      mem_we_q       <= mem_we_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = words_loaded_q;
  assign cpu_reset    = (state_q != DONE);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);

endmodule

// File: tb/tb_example_text_loader.sv
// tb/tb_example_text_loader.sv - scoreboard bench for the text memory loader
module tb_example_text_loader;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [31:0]  mem_wdata;
  logic [W:0]   words_loaded;
  logic         cpu_reset;
  logic         done;
  logic         error;

  example_text_loader #(.WORD_ADDR_BITS(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .words_loaded (words_loaded),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] addr;
    logic [31:0]  data;
    int           cyc;
  } wr_t;

  wr_t expq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  gap_mode = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write actual addr=%0h data=%0h required no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_wdata), 64'(e.data));
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_words_loaded", 64'(words_loaded), 64'd0);
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_reset_vals();
    reset = 1'b1;
  endtask

  // start together with a valid byte: that byte must not be taken
  task automatic do_start();
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit wr, input logic [W-1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    if (gap_mode) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        start = 1'($urandom_range(0, 1));
        @(negedge clock);
      end
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data = b;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual in_ready=%0b required 1", in_ready);
    end
    if (wr) expq.push_back('{a, d, cyc + 1});
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8], k == 3, a, d);
  endtask

  task automatic send_hdr(input logic [31:0] n);
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], 1'b0, '0, '0);
  endtask

  task automatic nominal_frame(input logic [7:0] trailer);
    do_start();
    send_hdr(32'd2);
    send_word(4'd0, 32'h12345678);
    send_word(4'd1, 32'hDEADBEEF);
    send_byte(trailer, 1'b0, '0, '0);
  endtask

  initial begin
    logic [7:0]  cs;
    logic [31:0] wd;

    repeat (2) @(negedge clock);
    do_reset();

    // nominal: XOR of 78 56 34 12 EF BE AD DE is 2A
    nominal_frame(8'h2A);
    chk("nom_done", 64'(done), 64'd1);
    chk("nom_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("nom_error", 64'(error), 64'd0);
    chk("nom_words_loaded", 64'(words_loaded), 64'd2);
    chk("nom_pending", 64'(expq.size()), 64'd0);

    do_reset();
    nominal_frame(8'h00);
    chk("bad_error", 64'(error), 64'd1);
    chk("bad_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("bad_done", 64'(done), 64'd0);
    in_valid = 1'b1;
    in_data = 8'h2A;
    chk("bad_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clock);
    in_valid = 1'b0;
    chk("bad_sticky_error", 64'(error), 64'd1);
    chk("bad_words_loaded", 64'(words_loaded), 64'd2);

    do_reset();
    do_start();
    send_hdr(32'd0);
    send_byte(8'h00, 1'b0, '0, '0);
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_words_loaded", 64'(words_loaded), 64'd0);

    do_reset();
    do_start();
    send_hdr(32'd17);
    chk("over_error", 64'(error), 64'd1);
    chk("over_in_ready", 64'(in_ready), 64'd0);
    chk("over_words_loaded", 64'(words_loaded), 64'd0);

    // largest legal image fills every address
    do_reset();
    do_start();
    send_hdr(32'd16);
    cs = 8'h00;
    for (int i = 0; i < 16; i++) begin
      wd = 32'hC0DE0000 ^ (32'(i) * 32'h01030507);
      cs = cs ^ wd[7:0] ^ wd[15:8] ^ wd[23:16] ^ wd[31:24];
      send_word(W'(i), wd);
    end
    send_byte(cs, 1'b0, '0, '0);
    chk("full_done", 64'(done), 64'd1);
    chk("full_words_loaded", 64'(words_loaded), 64'd16);
    chk("full_last_addr", 64'(mem_addr), 64'hF);

    do_reset();
    gap_mode = 1'b1;
    nominal_frame(8'h2A);
    gap_mode = 1'b0;
    chk("gap_done", 64'(done), 64'd1);
    chk("gap_words_loaded", 64'(words_loaded), 64'd2);

    do_reset();
    do_start();
    send_hdr(32'd2);
    send_word(4'd0, 32'h12345678);
    send_byte(8'hEF, 1'b0, '0, '0);
    send_byte(8'hBE, 1'b0, '0, '0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_reset_vals();
    reset = 1'b1;
    nominal_frame(8'h2A);
    chk("reload_done", 64'(done), 64'd1);
    chk("reload_words_loaded", 64'(words_loaded), 64'd2);

    repeat (3) @(negedge clock);
    chk("end_pending", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
